job_sched: RTL and testbench

JOB_SCHED -- requirements
Module: job_sched

---
 rtl/job_sched.sv | 179 +++++++++++++++++
 tb/tb_job_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/job_sched.sv
// job_sched: sequences one job through generation, encode run and output drain.
// It also holds the job configuration registers and counts busy cycles.
module job_sched #(
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             start,
    input  logic             abort,
    input  logic             get_fin,
    input  logic             out_last_hs,
    output logic             gen,
    output logic             run,
    output logic [15:0]      item_a,
    output logic             rand_latch,
    output logic [19:0]      addr_i,
    output logic [19:0]      addr_j,
    output logic [4:0]       remainder,
    output logic [15:0]      item_memory_num,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CYC_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_gen;
    logic              r_run;
    logic              r_busy;
    logic              r_done;
    logic              w_gen_next;
    logic              w_run_next;
    logic              w_busy_next;
    logic              w_done_next;

    logic [15:0]       r_item_a;
    logic [19:0]       r_addr_i;
    logic [19:0]       r_addr_j;
    logic [4:0]        r_remainder;
    logic [15:0]       r_item_memory_num;
    logic              r_cfg_err;
    logic [CYC_W-1:0]  r_cyc_cnt;

    logic              w_active;
    logic              w_start_ok;
    logic              w_item_last;
    logic              w_unused_wdata;

    // Upper write-data bits carry no configuration field.
    assign w_unused_wdata = ^cfg_wdata[31:20];

    // A job is in flight in GEN, RUN and DRAIN; only then are writes refused.
    assign w_active    = (r_state == ST_GEN) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    // start is honoured only when idle or finished, and abort always wins.
    assign w_start_ok  = start && !abort && !w_active;
    assign w_item_last = (r_item_a == r_item_memory_num);

    // State register plus registered status flags, so they move only on transition edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gen   <= 1'b0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_gen   <= w_gen_next;
            r_run   <= w_run_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state decode; abort overrides everything, get_fin outranks out_last_hs in RUN.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start)       w_state_next = ST_GEN;
                ST_GEN:   if (w_item_last) w_state_next = ST_RUN;
                ST_RUN:   if (get_fin)     w_state_next = ST_DRAIN;
                ST_DRAIN: if (out_last_hs) w_state_next = ST_DONE;
                ST_DONE:  if (start)       w_state_next = ST_GEN;
                default:                   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state; the values are captured by the state register.
    always_comb begin
        w_gen_next  = (w_state_next == ST_GEN);
        w_run_next  = (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
        w_busy_next = (w_state_next == ST_GEN) || (w_state_next == ST_RUN) ||
                      (w_state_next == ST_DRAIN);
        w_done_next = (w_state_next == ST_DONE);
    end

    // Item-memory address: walks 0..item_memory_num during GEN, otherwise parked at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_item_a <= 16'd0;
        end else if (abort) begin
            r_item_a <= 16'd0;
        end else if (r_state == ST_GEN) begin
            r_item_a <= w_item_last ? 16'd0 : (r_item_a + 16'd1);
        end else begin
            r_item_a <= 16'd0;
        end
    end

    // Configuration registers: writable only while no job is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_i          <= 20'd9;
            r_addr_j          <= 20'd2;
            r_remainder       <= 5'd20;
            r_item_memory_num <= 16'd1000;
        end else if (cfg_we && !w_active) begin
            case (cfg_addr)
                2'd0:    r_addr_i          <= cfg_wdata[19:0];
                2'd1:    r_addr_j          <= cfg_wdata[19:0];
                2'd2:    r_remainder       <= cfg_wdata[4:0];
                default: r_item_memory_num <= cfg_wdata[15:0];
            endcase
        end
    end

    // Sticky flag for writes refused mid-job; only an accepted start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else if (cfg_we && w_active) begin
            r_cfg_err <= 1'b1;
        end else if (w_start_ok) begin
            r_cfg_err <= 1'b0;
        end
    end

    // Busy-cycle counter: cleared by start, saturating, frozen by abort and when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt <= '0;
        end else if (w_start_ok) begin
            r_cyc_cnt <= '0;
        end else if (w_active && !abort && (r_cyc_cnt != {CYC_W{1'b1}})) begin
            r_cyc_cnt <= r_cyc_cnt + {{(CYC_W-1){1'b0}}, 1'b1};
        end
    end

    assign gen             = r_gen;
    assign run             = r_run;
    assign busy            = r_busy;
    assign done            = r_done;
    assign item_a          = r_item_a;
    assign addr_i          = r_addr_i;
    assign addr_j          = r_addr_j;
    assign remainder       = r_remainder;
    assign item_memory_num = r_item_memory_num;
    assign cfg_err         = r_cfg_err;
    assign cyc_cnt         = r_cyc_cnt;
    assign rand_latch      = (r_state == ST_GEN) && r_addr_i[0] && w_item_last;

endmodule

// File: tb/tb_job_sched.sv
// tb_job_sched: self-checking bench for job_sched (32-bit and 4-bit counter instances).
module tb_job_sched;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, abort, get_fin, out_last_hs;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;

    logic        gen, run, rand_latch, busy, done, cfg_err;
    logic [15:0] item_a, item_memory_num;
    logic [19:0] addr_i, addr_j;
    logic [4:0]  remainder;
    logic [31:0] cyc_cnt;

    logic        gen4, run4, rand_latch4, busy4, done4, cfg_err4;
    logic [15:0] item_a4, item_memory_num4;
    logic [19:0] addr_i4, addr_j4;
    logic [4:0]  remainder4;
    logic [3:0]  cyc_cnt4;

    always #5 clk = ~clk;

    job_sched #(.CYC_W(32)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .abort(abort), .get_fin(get_fin), .out_last_hs(out_last_hs),
        .gen(gen), .run(run), .item_a(item_a), .rand_latch(rand_latch),
        .addr_i(addr_i), .addr_j(addr_j), .remainder(remainder),
        .item_memory_num(item_memory_num), .busy(busy), .done(done),
        .cfg_err(cfg_err), .cyc_cnt(cyc_cnt)
    );

    job_sched #(.CYC_W(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .abort(abort), .get_fin(get_fin), .out_last_hs(out_last_hs),
        .gen(gen4), .run(run4), .item_a(item_a4), .rand_latch(rand_latch4),
        .addr_i(addr_i4), .addr_j(addr_j4), .remainder(remainder4),
        .item_memory_num(item_memory_num4), .busy(busy4), .done(done4),
        .cfg_err(cfg_err4), .cyc_cnt(cyc_cnt4)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
        logic [19:0] exp_i;
        logic [19:0] exp_j;
        logic [4:0]  exp_rem;
        logic [15:0] exp_num;
    } cfg_vec_t;

    cfg_vec_t    vecs [6];
    cfg_vec_t    sb_q [$];
    logic [15:0] latch_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cfg_vec_t e;
        int       gen_cycles;

        vecs[0] = '{2'd2, 32'hFFFF_FFE7, 20'd9,       20'd2,       5'd7, 16'd1000};
        vecs[1] = '{2'd0, 32'h1234_5678, 20'h45678,   20'd2,       5'd7, 16'd1000};
        vecs[2] = '{2'd1, 32'h000F_FFFF, 20'h45678,   20'hFFFFF,   5'd7, 16'd1000};
        vecs[3] = '{2'd3, 32'hDEAD_0003, 20'h45678,   20'hFFFFF,   5'd7, 16'd3};
        vecs[4] = '{2'd0, 32'h0000_0009, 20'd9,       20'hFFFFF,   5'd7, 16'd3};
        vecs[5] = '{2'd3, 32'h0000_0000, 20'd9,       20'hFFFFF,   5'd7, 16'd0};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        start = 1'b0; abort = 1'b0; get_fin = 1'b0; out_last_hs = 1'b0;

        // Reset state
        tick; tick;
        check("rst_gen", gen, 0);       check("rst_run", run, 0);
        check("rst_busy", busy, 0);     check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_item_a", item_a, 0); check("rst_cyc", cyc_cnt, 0);
        check("rst_addr_i", addr_i, 9); check("rst_addr_j", addr_j, 2);
        check("rst_rem", remainder, 20); check("rst_num", item_memory_num, 1000);
        $display("reset: checked");
        rst = 1'b0;
        tick;

        // Default job
        latch_q.push_back(16'd1000);
        start = 1'b1; tick; start = 1'b0;
        check("job1_gen", gen, 1); check("job1_busy", busy, 1);
        check("job1_item0", item_a, 0); check("job1_cyc0", cyc_cnt, 0);
        gen_cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!gen) break;
            gen_cycles++;
            if (rand_latch) begin
                check("job1_latch_pending", latch_q.size(), 1);
                if (latch_q.size() != 0) check("job1_latch_item", item_a, latch_q.pop_front());
            end
            tick;
        end
        check("job1_gen_cycles", gen_cycles, 1001);
        check("job1_latch_left", latch_q.size(), 0);
        check("job1_run", run, 1); check("job1_run_item", item_a, 0);
        repeat (20) tick;
        get_fin = 1'b1; tick; get_fin = 1'b0;
        check("job1_drain_run", run, 1); check("job1_drain_done", done, 0);
        repeat (4) tick;
        out_last_hs = 1'b1; tick; out_last_hs = 1'b0;
        check("job1_done", done, 1); check("job1_done_run", run, 0);
        check("job1_done_busy", busy, 0); check("job1_done_gen", gen, 0);
        check("job1_cyc", cyc_cnt, 1027); check("job1_cyc4_sat", cyc_cnt4, 15);
        repeat (2) tick;
        check("job1_hold_done", done, 1); check("job1_hold_cyc", cyc_cnt, 1027);
        check("job1_hold_cyc4", cyc_cnt4, 15);
        $display("job1: gen_cycles=%0d cyc_cnt=%0d cyc_cnt4=%0d", gen_cycles, cyc_cnt, cyc_cnt4);

        // Configuration table, applied while done
        for (int k = 0; k < 6; k++) begin
            cfg_we = 1'b1; cfg_addr = vecs[k].addr; cfg_wdata = vecs[k].data;
            sb_q.push_back(vecs[k]);
            tick;
            cfg_we = 1'b0;
            e = sb_q.pop_front();
            check("cfg_addr_i", addr_i, e.exp_i);
            check("cfg_addr_j", addr_j, e.exp_j);
            check("cfg_rem", remainder, e.exp_rem);
            check("cfg_num", item_memory_num, e.exp_num);
            $display("cfg[%0d]: addr=%0d data=%h", k, e.addr, e.data);
        end
        check("cfg_err_idle", cfg_err, 0);

        // Zero-item job with mid-job corner cases
        latch_q.push_back(16'd0);
        start = 1'b1; tick; start = 1'b0;
        check("job2_gen", gen, 1); check("job2_item", item_a, 0);
        check("job2_latch", rand_latch, 1); check("job2_done_clr", done, 0);
        check("job2_cyc0", cyc_cnt, 0);
        if (rand_latch && latch_q.size() != 0) check("job2_latch_item", item_a, latch_q.pop_front());
        check("job2_latch_left", latch_q.size(), 0);
        tick;
        check("job2_gen_off", gen, 0); check("job2_run", run, 1);
        check("job2_latch_off", rand_latch, 0); check("job2_cyc1", cyc_cnt, 1);
        out_last_hs = 1'b1; tick; out_last_hs = 1'b0;
        check("job2_early_last_done", done, 0); check("job2_early_last_busy", busy, 1);
        start = 1'b1; tick; start = 1'b0;
        check("job2_start_ign_busy", busy, 1); check("job2_start_ign_cyc", cyc_cnt, 3);
        check("job2_start_ign_gen", gen, 0);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'd7; tick; cfg_we = 1'b0;
        check("job2_cfg_blocked", addr_j, 20'hFFFFF); check("job2_cfg_err", cfg_err, 1);
        get_fin = 1'b1; out_last_hs = 1'b1; tick; get_fin = 1'b0; out_last_hs = 1'b0;
        check("job2_both_run", run, 1); check("job2_both_done", done, 0);
        check("job2_cyc5", cyc_cnt, 5); check("job2_cyc4_5", cyc_cnt4, 5);
        abort = 1'b1; tick; abort = 1'b0;
        check("abort_run", run, 0); check("abort_busy", busy, 0);
        check("abort_done", done, 0); check("abort_gen", gen, 0);
        check("abort_item", item_a, 0); check("abort_cyc", cyc_cnt, 5);
        check("abort_cfg_err", cfg_err, 1); check("abort_addr_j", addr_j, 20'hFFFFF);
        tick;
        check("abort_cyc_hold", cyc_cnt, 5);
        start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
        check("startabort_busy", busy, 0); check("startabort_gen", gen, 0);
        check("startabort_cyc", cyc_cnt, 5); check("startabort_cfg_err", cfg_err, 1);
        $display("job2: aborted in drain, cyc_cnt=%0d", cyc_cnt);

        // Restart after abort runs normally
        start = 1'b1; tick; start = 1'b0;
        check("job3_gen", gen, 1); check("job3_cfg_err_clr", cfg_err, 0);
        check("job3_cyc0", cyc_cnt, 0);
        tick;
        check("job3_run", run, 1);
        get_fin = 1'b1; tick; get_fin = 1'b0;
        out_last_hs = 1'b1; tick; out_last_hs = 1'b0;
        check("job3_done", done, 1); check("job3_cyc", cyc_cnt, 3);
        $display("job3: done=%0d cyc_cnt=%0d", done, cyc_cnt);

        // Reset mid-job overrides start and cfg_we
        start = 1'b1; tick; start = 1'b0;
        tick;
        rst = 1'b1; start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd5;
        tick;
        rst = 1'b0; start = 1'b0; cfg_we = 1'b0;
        check("midrst_busy", busy, 0); check("midrst_run", run, 0);
        check("midrst_gen", gen, 0); check("midrst_done", done, 0);
        check("midrst_cyc", cyc_cnt, 0); check("midrst_addr_i", addr_i, 9);
        check("midrst_addr_j", addr_j, 2); check("midrst_num", item_memory_num, 1000);
        check("midrst_cfg_err", cfg_err, 0);
        $display("midrst: busy=%0d addr_i=%0d", busy, addr_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
